// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM encoding, parity selection and prescale limits.
package uart_pkg;

  localparam int unsigned PRESCALE_W = 6;
  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(4);

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_type_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Bit periods shorter than the minimum are raised to it.
  function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..prescale-1 while enabled and flags the last cycle of each bit.
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign bit_done = enable && !clear && (cnt_q == (prescale - PRESCALE_W'(1)));

  // Wraps to zero at each bit end so every bit (and state) starts from count 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_done) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;

  uart_tx_bit_timer u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (state_q != IDLE),
    .clear    (state_q == IDLE),
    .prescale (pre_q),
    .bit_done (bit_done)
  );

  // Next-state, datapath and output values; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    pre_d    = pre_q;
    tx_out_d = 1'b1;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d  = START;
          shift_d  = p_data;
          idx_d    = '0;
          par_d    = (par_typ == PAR_ODD) ? ~(^p_data) : (^p_data);
          par_en_d = par_en;
          pre_d    = clamp_prescale(prescale);
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
            idx_d   = '0;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = par_d;
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      pre_q    <= '0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      pre_q    <= pre_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame shapes, parity, clamping, reset abort, back-to-back.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd4;
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL reset_state: tx_out=%b busy=%b, want 1/0", tx_out, busy);
    else pass_cnt++;
    // release reset with a request already pending: it must be taken at the first edge
    @(negedge clk);
    rst = 1'b0; data_valid = 1'b1; p_data = 8'hFF; prescale = 6'd4;
    @(posedge clk); #1 data_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b0 || busy !== 1'b1) $display("FAIL first_accept_after_reset: tx_out=%b busy=%b, want 0/1", tx_out, busy);
    else pass_cnt++;
    wait_idle("first_accept");
    @(negedge clk);
  endtask

  task automatic test_frame_a5_even;
    logic [10:0] exp = 11'b10101001010;
    int errs = 0;
    @(negedge clk);
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    for (int c = 0; c < 88; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tx_out !== exp[c/8] || busy !== 1'b1) begin
        if (errs < 5) $display("FAIL a5_bit cycle %0d: tx_out=%b busy=%b, want %b/1", c, tx_out, busy, exp[c/8]);
        errs++;
      end else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL a5_end: tx_out=%b busy=%b, want 1/0", tx_out, busy);
    else pass_cnt++;
  endtask

  task automatic test_frame_00_odd;
    logic [10:0] exp = 11'b11000000000;
    int errs = 0;
    @(negedge clk);
    p_data = 8'h00; par_en = 1'b1; par_typ = 1'b1; prescale = 6'd16; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    for (int c = 0; c < 176; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tx_out !== exp[c/16] || busy !== 1'b1) begin
        if (errs < 5) $display("FAIL odd00_bit cycle %0d: tx_out=%b busy=%b, want %b/1", c, tx_out, busy, exp[c/16]);
        errs++;
      end else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL odd00_end: tx_out=%b busy=%b, want 1/0", tx_out, busy);
    else pass_cnt++;
  endtask

  task automatic test_frame_ff_nopar;
    logic [9:0] exp = 10'b1111111110;
    int errs = 0;
    @(negedge clk);
    p_data = 8'hFF; par_en = 1'b0; par_typ = 1'b1; prescale = 6'd4; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tx_out !== exp[c/4] || busy !== 1'b1) begin
        if (errs < 5) $display("FAIL ff_bit cycle %0d: tx_out=%b busy=%b, want %b/1", c, tx_out, busy, exp[c/4]);
        errs++;
      end else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL ff_end: tx_out=%b busy=%b, want 1/0", tx_out, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] exp = 10'b1100000010;
    int errs = 0;
    @(negedge clk);
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    // cycles 32..39 carry data bit 3 (a 0 for 0xA5)
    for (int c = 0; c < 35; c++) @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b0 || busy !== 1'b1) $display("FAIL abort_pre: tx_out=%b busy=%b, want 0/1", tx_out, busy);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL abort_async: tx_out=%b busy=%b, want 1/0", tx_out, busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        if (errs < 5) $display("FAIL abort_no_resume cycle %0d: tx_out=%b busy=%b, want 1/0", c, tx_out, busy);
        errs++;
      end else pass_cnt++;
    end
    p_data = 8'h81; par_en = 1'b0; prescale = 6'd4; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tx_out !== exp[c/4] || busy !== 1'b1) begin
        if (errs < 10) $display("FAIL abort_clean_bit cycle %0d: tx_out=%b busy=%b, want %b/1", c, tx_out, busy, exp[c/4]);
        errs++;
      end else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL abort_clean_end: tx_out=%b busy=%b, want 1/0", tx_out, busy);
    else pass_cnt++;
  endtask

  task automatic test_ignore_midframe;
    logic [9:0] exp = 10'b1001111000;
    int errs = 0;
    @(negedge clk);
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tx_out !== exp[c/8] || busy !== 1'b1) begin
        if (errs < 5) $display("FAIL midframe_bit cycle %0d: tx_out=%b busy=%b, want %b/1", c, tx_out, busy, exp[c/8]);
        errs++;
      end else pass_cnt++;
      if (c == 30) begin
        prescale = 6'd16; p_data = 8'h5A; par_en = 1'b1; data_valid = 1'b1;
      end
      if (c == 36) data_valid = 1'b0;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total_cnt++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        if (errs < 10) $display("FAIL midframe_dropped cycle %0d: tx_out=%b busy=%b, want 1/0", c, tx_out, busy);
        errs++;
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp = 10'b1100000010;
    int errs = 0;
    @(negedge clk);
    p_data = 8'h81; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd2; data_valid = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        total_cnt++;
        if (tx_out !== exp[c/4] || busy !== 1'b1) begin
          if (errs < 5) $display("FAIL b2b_bit frame %0d cycle %0d: tx_out=%b busy=%b, want %b/1", f, c, tx_out, busy, exp[c/4]);
          errs++;
        end else pass_cnt++;
        if (f == 1 && c == 0) data_valid = 1'b0;
      end
      @(negedge clk);
      total_cnt++;
      if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_gap frame %0d: tx_out=%b busy=%b, want 1/0", f, tx_out, busy);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (tx_out !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_final_idle: tx_out=%b busy=%b, want 1/0", tx_out, busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame_a5_even();
    test_frame_00_odd();
    test_frame_ff_nopar();
    test_reset_mid_frame();
    test_ignore_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port p_data  input  DATA_WIDTH  parallel payload to transmit.
REQ-005 SHALL have port data_valid  input  1  request to send p_data; sampled only when busy=0.
REQ-006 SHALL have port par_en  input  1  1 = parity bit inserted after data.
REQ-007 SHALL have port par_typ  input  1  0 = even, 1 = odd parity.
REQ-008 SHALL have port prescale  input  6  clk cycles per serial bit (oversampling ratio shared with receiver).
REQ-009 SHALL have port tx_out  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is in flight.

Function
REQ-011 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: tx_out=1, busy=0; data_valid=1 at an edge -> capture p_data, par_en, par_typ, prescale; go to START.
REQ-013 SHALL drive tx_out=0 and busy=1 in the first cycle after acceptance (latency 1 clk).
REQ-014 Each bit SHALL last exactly P clk cycles, P = captured prescale; a bit timer counts 0..P-1 and flags bit end at P-1.
REQ-015 Captured prescale values 0..3 SHALL be clamped to P=4; mid-frame prescale changes SHALL be ignored.
REQ-016 START -> DATA at bit end; DATA sends DATA_WIDTH bits LSB first, bit index 0..DATA_WIDTH-1.
REQ-017 DATA last bit end -> PARITY if captured par_en=1, else STOP.
REQ-018 Parity bit SHALL be XOR of captured data (even) or its inverse (odd), computed at capture.
REQ-019 STOP drives tx_out=1 for P cycles, then returns to IDLE; busy=0 from the first IDLE cycle.
REQ-020 Frame length SHALL be P*(DATA_WIDTH+2+par_en) cycles from first start cycle to last stop cycle.
REQ-021 data_valid while busy=1 SHALL be ignored; no queuing.
REQ-022 Back-to-back: valid held high -> exactly one IDLE cycle (tx_out=1) between stop end and next start.
REQ-023 tx_out and busy SHALL be registered outputs (glitch-free line).
REQ-024 Bit timer and bit index SHALL reset to 0 on every state transition; no wrap-around beyond P-1 or DATA_WIDTH-1.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, tx_out=1, busy=0, timer=0, index=0, captured registers=0.
REQ-026 rst asserted mid-frame SHALL abort the frame; no partial resume after release.
REQ-027 First acceptance after rst release SHALL take effect at the first rising edge with rst=0.

Structure
REQ-028 State encoding, parity-type constants and minimum-prescale constant (4) SHALL live in shared package uart_pkg.
REQ-029 Bit timer SHALL be sub-module uart_tx_bit_timer (inputs enable, clear, prescale; output bit_done).
REQ-030 Datapath (shift register, parity, index) and FSM SHALL stay in uart_tx.

Verification
REQ-031 p_data=0xA5, par_en=1, par_typ=0, prescale=8 -> tx_out 0,1,0,1,0,0,1,0,1,0(parity),1 each 8 clks; busy high 88 clks.
REQ-032 p_data=0x00, par_en=1, par_typ=1, prescale=16 -> parity bit 1; frame 176 clks.
REQ-033 p_data=0xFF, par_en=0, prescale=4 -> 10 bits, 40 clks, no parity slot.
REQ-034 rst pulse during DATA bit 3 -> tx_out=1, busy=0 same cycle; next frame starts clean.
REQ-035 prescale 8->16 and second data_valid mid-frame -> frame timing unchanged at 8; second request dropped.
REQ-036 data_valid held high, prescale=2 -> P=4 used; one idle-high cycle between consecutive frames.
